// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the framer state encoding and the default frame/oversampling constants.
package uart_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
// RESET_VAL sets the value both flops take during reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start/data/[parity]/stop detection with a
// single-word valid/ready holding register and framing/overrun/parity flags.
// Ports: clk, reset (sync, active-high), sample_tick (OVERSAMPLE per bit),
//        rx (async line, idle high), data_out/data_valid/data_ready (word
//        handshake), framing_err, overrun_err, parity_err (one-clk pulses).
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after the
// data bits; otherwise parity_err is constant 0.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    logic rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_e            state, state_n;
    logic [TICK_W-1:0]    tick_cnt, tick_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [DATA_BITS-1:0] data_out_n;
    logic                 valid_n, fe_n, oe_n;
    logic [TICK_W-1:0]    limit;
    logic                 fire;
    logic                 par_ok;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_n, pe_n;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shift_reg   <= shift_n;
            data_out    <= data_out_n;
            data_valid  <= valid_n;
            framing_err <= fe_n;
            overrun_err <= oe_n;
`ifdef UART_RX_PARITY_EN
            par_bit     <= par_n;
            parity_err  <= pe_n;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Next-state, sampling and delivery logic
    always_comb begin
        state_n    = state;
        tick_n     = tick_cnt;
        bit_n      = bit_cnt;
        shift_n    = shift_reg;
        data_out_n = data_out;
        valid_n    = data_valid && !data_ready;
        fe_n       = 1'b0;
        oe_n       = 1'b0;
        par_ok     = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_n      = par_bit;
        pe_n       = 1'b0;
`endif

        // START only waits half a bit so later samples land mid-bit
        limit = (state == START) ? TICK_W'(OVERSAMPLE / 2 - 1) : TICK_W'(OVERSAMPLE - 1);
        fire  = sample_tick && (tick_cnt == limit);

        if (sample_tick) begin
            tick_n = tick_cnt + TICK_W'(1);
        end

        case (state)
            IDLE: begin
                if (sample_tick && !rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (fire) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
                    bit_n   = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (fire) begin
                    par_n   = rx_s;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (fire) begin
`ifdef UART_RX_PARITY_EN
                    // Even parity: data bits plus parity bit XOR to zero
                    par_ok = ~(^shift_reg ^ par_bit);
                    pe_n   = ~par_ok;
`endif
                    if (!rx_s) begin
                        fe_n    = 1'b1;
                        state_n = WAIT_IDLE;
                    end else begin
                        state_n = IDLE;
                        if (par_ok) begin
                            if (!data_valid || data_ready) begin
                                data_out_n = shift_reg;
                                valid_n    = 1'b1;
                            end else begin
                                oe_n = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break is one error
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n != state || state == IDLE || state == WAIT_IDLE) begin
            tick_n = '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer at default parameters.
// Runs a table of whole frames, then hand-written glitch, break, overrun,
// parity (when UART_RX_PARITY_EN is defined) and mid-frame reset sequences.
module tb_uart_rx_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       framing_err;
    logic       overrun_err;
    logic       parity_err;

    always #5 clk = ~clk;

    uart_rx_framer dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    int checks = 0;
    int errors = 0;

    // Cumulative event counters, written only by the monitor
    int         words = 0;
    int         fe_cnt = 0;
    int         oe_cnt = 0;
    int         pe_cnt = 0;
    int         valid_cycles = 0;
    logic [7:0] last_word = 8'h00;
    logic       prev_valid = 1'b0;

    int b_words, b_fe, b_oe, b_pe, b_vc;

    // One sample_tick every 4 clocks, changed on negedges
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (framing_err) fe_cnt++;
        if (overrun_err) oe_cnt++;
        if (parity_err)  pe_cnt++;
        if (data_valid)  valid_cycles++;
        if (data_valid && !prev_valid) begin
            words++;
            last_word = data_out;
        end
        prev_valid = data_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_words = words;
        b_fe    = fe_cnt;
        b_oe    = oe_cnt;
        b_pe    = pe_cnt;
        b_vc    = valid_cycles;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) $display("note: parity argument unused");
`endif
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_word;
        int         exp_words;
        int         exp_fe;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{data: 8'h55, stop: 1'b1, exp_word: 8'h55, exp_words: 1, exp_fe: 0};
        vt[1] = '{data: 8'h00, stop: 1'b1, exp_word: 8'h00, exp_words: 1, exp_fe: 0};
        vt[2] = '{data: 8'hFF, stop: 1'b1, exp_word: 8'hFF, exp_words: 1, exp_fe: 0};
        vt[3] = '{data: 8'h81, stop: 1'b1, exp_word: 8'h81, exp_words: 1, exp_fe: 0};
        vt[4] = '{data: 8'hA5, stop: 1'b0, exp_word: 8'h81, exp_words: 0, exp_fe: 1};

        reset      = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_fe", 32'(framing_err), 32'h0);
        check("reset_oe", 32'(overrun_err), 32'h0);
        check("reset_pe", 32'(parity_err), 32'h0);
        reset = 1'b0;
        idle_bits(2);

        // Table of whole frames with data_ready held high
        for (int v = 0; v < 5; v++) begin
            snap();
            send_frame(vt[v].data, ^vt[v].data, vt[v].stop);
            idle_bits(2);
            check($sformatf("vec%0d_words", v), 32'(words - b_words), 32'(vt[v].exp_words));
            check($sformatf("vec%0d_valid_cycles", v), 32'(valid_cycles - b_vc), 32'(vt[v].exp_words));
            check($sformatf("vec%0d_word", v), 32'(last_word), 32'(vt[v].exp_word));
            check($sformatf("vec%0d_fe", v), 32'(fe_cnt - b_fe), 32'(vt[v].exp_fe));
            check($sformatf("vec%0d_oe", v), 32'(oe_cnt - b_oe), 32'h0);
            check($sformatf("vec%0d_pe", v), 32'(pe_cnt - b_pe), 32'h0);
        end

        // Short low glitch is rejected at the start-bit midpoint
        snap();
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(32);
        check("glitch_words", 32'(words - b_words), 32'h0);
        check("glitch_fe", 32'(fe_cnt - b_fe), 32'h0);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        idle_bits(2);
        check("post_glitch_words", 32'(words - b_words), 32'h1);
        check("post_glitch_word", 32'(last_word), 32'h5A);

        // Bad stop bit followed by a held break, then a good frame
        snap();
        send_frame(8'hA3, ^8'hA3, 1'b0);
        wait_ticks(40);
        idle_bits(2);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        idle_bits(2);
        check("break_fe", 32'(fe_cnt - b_fe), 32'h1);
        check("break_words", 32'(words - b_words), 32'h1);
        check("break_word", 32'(last_word), 32'h3C);
        check("break_oe", 32'(oe_cnt - b_oe), 32'h0);

        // Overrun: consumer stalled across two frames
        snap();
        @(negedge clk);
        data_ready = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1);
        idle_bits(1);
        send_frame(8'h22, ^8'h22, 1'b1);
        idle_bits(2);
        check("ovr_data_out", 32'(data_out), 32'h11);
        check("ovr_valid", 32'(data_valid), 32'h1);
        check("ovr_oe", 32'(oe_cnt - b_oe), 32'h1);
        check("ovr_words", 32'(words - b_words), 32'h1);
        @(negedge clk);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_consumed_valid", 32'(data_valid), 32'h0);
        check("ovr_consumed_data", 32'(data_out), 32'h11);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones so the parity bit must be 1
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        idle_bits(2);
        check("par_bad_pe", 32'(pe_cnt - b_pe), 32'h1);
        check("par_bad_words", 32'(words - b_words), 32'h0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        check("par_good_pe", 32'(pe_cnt - b_pe), 32'h0);
        check("par_good_words", 32'(words - b_words), 32'h1);
        check("par_good_word", 32'(last_word), 32'h07);
`endif

        // Reset partway through the data bits
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_data_out", 32'(data_out), 32'h0);
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        check("mid_rst_errs", 32'({framing_err, overrun_err, parity_err}), 32'h0);
        reset = 1'b0;
        idle_bits(2);
        send_frame(8'hF0, ^8'hF0, 1'b1);
        idle_bits(2);
        check("mid_rst_words", 32'(words - b_words), 32'h1);
        check("mid_rst_word", 32'(last_word), 32'hF0);
        check("mid_rst_fe", 32'(fe_cnt - b_fe), 32'h0);
        check("mid_rst_oe", 32'(oe_cnt - b_oe), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
